// File: rtl/channel_readout_seq.sv
// Readout sequencer: walks the channels after a start, captures each replayed
// burst behind a header word and streams the framed words out of a FWFT FIFO.
module channel_readout_seq #(
  parameter int NCH        = 4,
  parameter int SIZE       = 8,
  parameter int WIDTH      = 12,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_AW    = 9
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [SIZE-1:0]        howmany,
  output logic [NCH-1:0]         rd_request,
  input  logic [NCH*WIDTH-1:0]   ch_dout,
  output logic [WIDTH+1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = SIZE + $clog2(RD_LATENCY + 1) + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = WIDTH + 2;

  typedef enum logic [2:0] {IDLE, ROOM, HDR, CAP, NEXT, FIN} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [SIZE-1:0]   hm;
  logic [CNT_W-1:0]  cnt;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   free_space;

  logic              push;
  logic              pop;
  logic [DW-1:0]     push_data;
  logic              room_ok;
  logic              capture;
  logic              final_sample;
  logic              last_ch;
  logic [CNT_W-1:0]  first_cnt;
  logic [CNT_W-1:0]  final_cnt;
  logic [WIDTH-1:0]  sample;

  // Reserving hm+1 slots before HDR is the only backpressure: channels cannot stall.
  assign free_space   = (FIFO_AW+1)'(DEPTH) - count;
  assign room_ok      = free_space >= ((FIFO_AW+1)'(hm) + (FIFO_AW+1)'(1));
  assign last_ch      = (ch == CH_W'(NCH - 1));
  assign first_cnt    = CNT_W'(RD_LATENCY - 1);
  assign final_cnt    = first_cnt + CNT_W'(hm) - CNT_W'(1);
  assign capture      = (state == CAP) && (cnt >= first_cnt);
  assign final_sample = capture && (cnt == final_cnt);
  assign sample       = ch_dout[ch*WIDTH +: WIDTH];

  always_comb begin
    // NOTE: defaults first, so every path assigns push/push_data and no latch is inferred.
    push      = 1'b0;
    push_data = '0;
    if (state == HDR) begin
      push      = 1'b1;
      push_data = {1'b1, last_ch && (hm == '0), WIDTH'(ch)};
    end else if (capture) begin
      push      = 1'b1;
      push_data = {1'b0, last_ch && final_sample, sample};
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array carries no reset; pointers and count alone define emptiness.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      ch         <= '0;
      hm         <= '0;
      cnt        <= '0;
      rd_request <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_request <= '0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hm    <= howmany;
            ch    <= '0;
            busy  <= 1'b1;
            state <= ROOM;
          end
        end
        ROOM: begin
          if (room_ok) begin
            rd_request <= NCH'(1) << ch;
            state      <= HDR;
          end
        end
        HDR: begin
          cnt   <= '0;
          state <= (hm == '0) ? NEXT : CAP;
        end
        CAP: begin
          cnt <= cnt + CNT_W'(1);
          if (final_sample) state <= NEXT;
        end
        NEXT: begin
          if (last_ch) begin
            state <= FIN;
          end else begin
            ch    <= ch + CH_W'(1);
            state <= ROOM;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_readout_seq.sv
// Bench for channel_readout_seq: two instances (read latency 3 and 1) share the
// stimulus; each lane has channel models and a scoreboard of framed words.
module tb_channel_readout_seq;

  localparam int NCH     = 4;
  localparam int SIZE    = 8;
  localparam int WIDTH   = 12;
  localparam int FIFO_AW = 8;
  localparam int DW      = WIDTH + 2;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] howmany = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pass_id = 0;
  int model_hm = 0;
  int ready_mode = 1;
  bit timing_on = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, lane, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int RL = (g == 0) ? 3 : 1;

    logic [NCH-1:0]       rd_request;
    logic [NCH*WIDTH-1:0] ch_dout;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    int            age [NCH] = '{default: 100000};
    logic [DW-1:0] exp_w [4096];
    int            wr_i = 0, rd_i = 0, pass_base = 0, seen_pass = 0;
    int            exp_ch = 0, hdr0 = 0, done_cnt = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] held = '0;

    channel_readout_seq #(
      .NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH), .RD_LATENCY(RL), .FIFO_AW(FIFO_AW)
    ) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .howmany(howmany),
      .rd_request(rd_request), .ch_dout(ch_dout), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Channel i replays 0x100*i+n, n-th sample RL cycles after its request; 0xEEE otherwise.
    always @(posedge CLK) begin
      for (int i = 0; i < NCH; i++)
        age[i] <= rd_request[i] ? 1 : ((age[i] < 100000) ? age[i] + 1 : age[i]);
    end

    always_comb begin
      ch_dout = '0;
      for (int i = 0; i < NCH; i++) begin
        if (age[i] >= RL && (age[i] - RL) < model_hm)
          ch_dout[i*WIDTH +: WIDTH] = WIDTH'(256 * i + age[i] - RL);
        else
          ch_dout[i*WIDTH +: WIDTH] = 12'hEEE;
      end
    end

    always @(negedge CLK) begin
      if (RESET) begin
        wr_i = 0; rd_i = 0; pass_base = 0; exp_ch = 0; stalled = 1'b0;
      end else begin
        if (seen_pass != pass_id) begin
          seen_pass = pass_id;
          pass_base = wr_i;
          exp_ch    = 0;
          for (int c = 0; c < NCH; c++) begin
            exp_w[wr_i] = {1'b1, (c == NCH - 1 && model_hm == 0), WIDTH'(c)};
            wr_i++;
            for (int k = 0; k < model_hm; k++) begin
              exp_w[wr_i] = {1'b0, (c == NCH - 1 && k == model_hm - 1), WIDTH'(256 * c + k)};
              wr_i++;
            end
          end
        end
        if (stalled) begin
          check("valid held under stall", g, out_valid, 1);
          check("data held under stall", g, out_data, held);
        end
        if (out_valid && out_ready) begin
          check("word expected", g, rd_i < wr_i, 1);
          if (rd_i < wr_i) begin
            check("stream word", g, out_data, exp_w[rd_i]);
            rd_i++;
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
        if (rd_request != '0) begin
          check("rd_request one-hot", g, rd_request, (exp_ch < NCH) ? (1 << exp_ch) : 0);
          if (exp_ch == 0) hdr0 = cyc;
          exp_ch++;
        end
        if (done) begin
          done_cnt++;
          check("channels visited at done", g, exp_ch, NCH);
          if (timing_on)
            check("done latency from HDR0", g, cyc - hdr0,
                  (model_hm == 0) ? 12 : 4 * (model_hm + RL + 2));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_pass(input int hm);
    check("idle before start", 0, g_lane[0].busy, 0);
    check("idle before start", 1, g_lane[1].busy, 0);
    start = 1'b1; howmany = SIZE'(hm); model_hm = hm; pass_id++;
    tick();
    start = 1'b0;
    check("busy one cycle after start", 0, g_lane[0].busy, 1);
    check("busy one cycle after start", 1, g_lane[1].busy, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while ((g_lane[0].done_cnt < target || g_lane[1].done_cnt < target) && n < budget) begin
      tick();
      n++;
    end
    check("passes completed", 0, g_lane[0].done_cnt, target);
    check("passes completed", 1, g_lane[1].done_cnt, target);
  endtask

  task automatic wait_drain(input int budget, input int words);
    int n = 0;
    while ((g_lane[0].rd_i != g_lane[0].wr_i || g_lane[1].rd_i != g_lane[1].wr_i) && n < budget) begin
      tick();
      n++;
    end
    check("words drained", 0, g_lane[0].rd_i - g_lane[0].pass_base, words);
    check("words drained", 1, g_lane[1].rd_i - g_lane[1].pass_base, words);
  endtask

  task automatic check_reset_outputs();
    check("rst rd_request", 0, g_lane[0].rd_request, 0);
    check("rst rd_request", 1, g_lane[1].rd_request, 0);
    check("rst busy", 0, g_lane[0].busy, 0);
    check("rst busy", 1, g_lane[1].busy, 0);
    check("rst done", 0, g_lane[0].done, 0);
    check("rst done", 1, g_lane[1].done, 0);
    check("rst out_valid", 0, g_lane[0].out_valid, 0);
    check("rst out_valid", 1, g_lane[1].out_valid, 0);
    check("rst out_data", 0, g_lane[0].out_data, 0);
    check("rst out_data", 1, g_lane[1].out_data, 0);
  endtask

  initial begin
    int n;
    tick(2);
    check_reset_outputs();
    RESET = 1'b0;
    tick(2);

    // Basic pass, hm=5, consumer always ready.
    timing_on = 1'b1;
    start_pass(5);
    wait_done(1, 200);
    wait_drain(50, 24);
    check("model header ch0", 0, g_lane[0].exp_w[0], 14'h2000);
    check("model sample 0x004", 0, g_lane[0].exp_w[5], 14'h0004);
    check("model header ch1", 0, g_lane[0].exp_w[6], 14'h2001);
    check("model last 0x304", 0, g_lane[0].exp_w[23], 14'h1304);

    // Header-only pass.
    start_pass(0);
    wait_done(2, 100);
    wait_drain(50, 4);
    check("model last header 3", 0, g_lane[0].exp_w[g_lane[0].pass_base + 3], 14'h3003);

    // Full FIFO: stall in ROOM before channel 1, then release.
    timing_on = 1'b0;
    ready_mode = 0;
    tick();
    start_pass(255);
    tick(400);
    for (int l = 0; l < 2; l++) begin
      check("requests while full", l, (l == 0) ? g_lane[0].exp_ch : g_lane[1].exp_ch, 1);
    end
    check("busy while stalled", 0, g_lane[0].busy, 1);
    check("busy while stalled", 1, g_lane[1].busy, 1);
    check("valid while stalled", 0, g_lane[0].out_valid, 1);
    check("valid while stalled", 1, g_lane[1].out_valid, 1);
    ready_mode = 1;
    wait_done(3, 3000);
    wait_drain(400, 1024);

    // Dropped start and howmany changes mid-pass.
    timing_on = 1'b1;
    start_pass(5);
    tick(4);
    start = 1'b1; howmany = 8'd9;
    tick();
    start = 1'b0; howmany = 8'd17;
    tick(3);
    howmany = 8'd2;
    wait_done(4, 200);
    wait_drain(50, 24);
    tick(20);
    check("no extra pass", 0, g_lane[0].done_cnt, 4);
    check("no extra pass", 1, g_lane[1].done_cnt, 4);

    // Reset during CAP of channel 2.
    start_pass(5);
    n = 0;
    while (g_lane[0].rd_request != 4'b0100 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reached channel 2", 0, g_lane[0].rd_request, 4'b0100);
    @(posedge CLK);
    #1;
    tick();
    RESET = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    RESET = 1'b0;
    tick(8);
    check("idle after reset", 0, g_lane[0].busy, 0);
    check("idle after reset", 1, g_lane[1].busy, 0);
    check("fifo empty after reset", 0, g_lane[0].out_valid, 0);
    check("fifo empty after reset", 1, g_lane[1].out_valid, 0);
    check("no done from aborted pass", 0, g_lane[0].done_cnt, 4);
    check("no done from aborted pass", 1, g_lane[1].done_cnt, 4);
    start_pass(5);
    wait_done(5, 200);
    wait_drain(50, 24);

    // Random consumer backpressure.
    timing_on = 1'b0;
    ready_mode = 2;
    start_pass(20);
    wait_done(6, 2000);
    wait_drain(500, 84);
    start_pass(3);
    wait_done(7, 2000);
    wait_drain(500, 16);
    ready_mode = 1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
